// File: rtl/regfile_mp_scoreboard.sv
// Two-read / two-write register file with a per-register pending scoreboard.
// Port A wins same-index write collisions; optional hardwired-zero R0 and write-to-read bypass.
module regfile_mp_scoreboard #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] Read_Register1,
  input  logic [ADDR_WIDTH-1:0] Read_Register2,
  output logic [DATA_WIDTH-1:0] Read_Data1,
  output logic [DATA_WIDTH-1:0] Read_Data2,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] Write_Reg,
  input  logic [DATA_WIDTH-1:0] Write_Data,
  input  logic                  RegWrite2,
  input  logic [ADDR_WIDTH-1:0] Write_Reg2,
  input  logic [DATA_WIDTH-1:0] Write_Data2,
  input  logic                  Issue_Valid,
  input  logic [ADDR_WIDTH-1:0] Issue_Reg,
  output logic                  Busy1,
  output logic                  Busy2,
  output logic [ADDR_WIDTH:0]   Pending_Count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]      pend_q;
  logic [DEPTH-1:0]      pend_d;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic [ADDR_WIDTH:0]   cnt_d;

  logic we_a;
  logic we_b;
  logic we_b_store;
  logic iss;

  // Index 0 is silently dropped everywhere when it is hardwired to zero.
  assign we_a       = RegWrite    && !(ZERO_REG && (Write_Reg  == '0));
  assign we_b       = RegWrite2   && !(ZERO_REG && (Write_Reg2 == '0));
  assign iss        = Issue_Valid && !(ZERO_REG && (Issue_Reg  == '0));
  assign we_b_store = we_b && !(we_a && (Write_Reg2 == Write_Reg));

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      logic hit_a;
      logic hit_b;
      logic hit_i;
      assign hit_a = we_a       && (Write_Reg  == ADDR_WIDTH'(gi));
      assign hit_b = we_b_store && (Write_Reg2 == ADDR_WIDTH'(gi));
      assign hit_i = iss        && (Issue_Reg  == ADDR_WIDTH'(gi));
      assign mem_d[gi]  = hit_a ? Write_Data : (hit_b ? Write_Data2 : mem_q[gi]);
      // A same-cycle issue names a newer producer, so it beats the clearing write.
      assign pend_d[gi] = hit_i ? 1'b1 : ((hit_a || hit_b) ? 1'b0 : pend_q[gi]);
    end
  endgenerate

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_d = cnt_d + (ADDR_WIDTH + 1)'(pend_d[i]);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  logic [ADDR_WIDTH-1:0] ra    [2];
  logic [DATA_WIDTH-1:0] rdata [2];
  logic                  busy  [2];

  assign ra[0] = Read_Register1;
  assign ra[1] = Read_Register2;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic byp_a;
      logic byp_b;
      logic is_zero;
      assign byp_a   = BYPASS && we_a && (Write_Reg  == ra[gi]);
      assign byp_b   = BYPASS && we_b && (Write_Reg2 == ra[gi]);
      assign is_zero = ZERO_REG && (ra[gi] == '0);
      assign rdata[gi] = is_zero ? '0 :
                         byp_a   ? Write_Data :
                         byp_b   ? Write_Data2 : mem_q[ra[gi]];
      assign busy[gi]  = !is_zero && !byp_a && !byp_b && pend_q[ra[gi]];
    end
  endgenerate

  assign Read_Data1    = rdata[0];
  assign Read_Data2    = rdata[1];
  assign Busy1         = busy[0];
  assign Busy2         = busy[1];
  assign Pending_Count = cnt_q;

endmodule

// File: doc/regfile_mp_scoreboard.md
Name: regfile_mp_scoreboard

Overview:
Parametrised successor to the 16x16 two-read/one-write register file of the 16-bit ISA datapath. Generalises data width and depth. Adds a second write port, an optional hardwired-zero R0, optional same-cycle write-to-read bypass, and a per-register pending (scoreboard) bit with a pending count. Sits between decode/issue and writeback of the pipelined core.

Parameters:
DATA_WIDTH, 16, bits per register
ADDR_WIDTH, 4, register index width; DEPTH = 2**ADDR_WIDTH
ZERO_REG, 1, 1 = R0 always reads 0; writes and issues to R0 are ignored
BYPASS, 1, 1 = a write in the current cycle is forwarded combinationally to matching read ports

Ports:
Clk  input  1  clock; all state updates on the rising edge
Reset  input  1  synchronous, active-high reset
Read_Register1  input  ADDR_WIDTH  read port 1 index (rs)
Read_Register2  input  ADDR_WIDTH  read port 2 index (rt)
Read_Data1  output  DATA_WIDTH  read port 1 data, combinational
Read_Data2  output  DATA_WIDTH  read port 2 data, combinational
RegWrite  input  1  write enable, port A (priority)
Write_Reg  input  ADDR_WIDTH  write index, port A (rd)
Write_Data  input  DATA_WIDTH  write data, port A
RegWrite2  input  1  write enable, port B
Write_Reg2  input  ADDR_WIDTH  write index, port B
Write_Data2  input  DATA_WIDTH  write data, port B
Issue_Valid  input  1  marks Issue_Reg pending (new in-flight producer)
Issue_Reg  input  ADDR_WIDTH  destination being issued
Busy1  output  1  pending status of Read_Register1
Busy2  output  1  pending status of Read_Register2
Pending_Count  output  ADDR_WIDTH+1  registered number of pending registers

Behaviour:
- Reset (sync, high at a rising edge): all registers := 0, all pending bits := 0, Pending_Count := 0. Reset overrides writes and issues in the same cycle. Mid-operation reset discards all in-flight state. The cycle after reset: Read_Data* = 0, Busy* = 0.
- Writes take effect at the rising edge when enabled. Latency is 1 cycle to the array; with BYPASS=1 they are visible to reads in the same cycle.
- Both ports writing the same index in the same cycle: port A data stored; port B dropped. Different indices: both stored.
- ZERO_REG=1: writes to index 0 ignored; Read_Data* = 0 for index 0; Busy* = 0 for index 0; Issue to 0 ignored.
- Read data (per port, combinational):
  - BYPASS=1 and RegWrite and Write_Reg matches: Write_Data.
  - Else BYPASS=1 and RegWrite2 and Write_Reg2 matches: Write_Data2.
  - Else the stored value.
  - BYPASS=0: always the stored value.
- Pending bits, evaluated at each rising edge (no reset):
  - Each enabled write clears pending[target].
  - Issue_Valid sets pending[Issue_Reg].
  - Issue and write to the same index in the same cycle: set wins, because the new producer supersedes.
  - A write to a non-pending register is legal: data stored, pending stays 0.
- Busy outputs:
  - Busy1 = pending[Read_Register1], except with BYPASS=1 Busy1 = 0 when an enabled write (either port) targets Read_Register1 this cycle.
  - Busy2 follows the same rule for Read_Register2.
  - Busy does not reflect a same-cycle Issue; that takes effect next cycle.
- Pending_Count = population count of the pending bits after the edge update. Range 0..DEPTH, or 0..DEPTH-1 with ZERO_REG. It never wraps because width is ADDR_WIDTH+1.
- Reads are never blocked. Stalling on Busy is the issue logic's responsibility.

Test Plan:
1. Reset high 1 cycle, then read R1/R2 -> Read_Data1=Read_Data2=0x0000, Busy1=Busy2=0, Pending_Count=0.
2. RegWrite=1, Write_Reg=3, Write_Data=0x0020, Read_Register2=3 in the same cycle, BYPASS=1 -> Read_Data2=0x0020 before the edge. After the edge with RegWrite=0 -> still 0x0020. With BYPASS=0 -> 0x0000 before the edge, 0x0020 after.
3. Port A writes R5=0x1111 and port B writes R5=0x2222 in the same cycle -> R5 reads 0x1111. Port B writes R6=0xBEEF alongside A writing R5 -> both stored.
4. Issue R4 -> Busy on R4 =1 next cycle, Pending_Count=1. Write R4=0x00AA via port B while Issue_Valid to R4 in the same cycle -> Busy stays 1, data=0x00AA. Next write to R4 with no issue -> Busy=0, Pending_Count=0.
5. ZERO_REG=1: write R0=0xFFFF and issue R0 -> Read_Data1(R0)=0x0000, Busy1=0, Pending_Count unchanged.
6. Issue R1..R15 over 15 cycles -> Pending_Count=15. Assert Reset simultaneously with a write to R2=0x1234 -> all registers 0, Pending_Count=0, R2 reads 0x0000.
